// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between icache fetches and dcache reads/writes.
// Optional performance counters are built only when MEMARB_PERF_EN is defined.
module memory_arbiter #(
  parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
`ifdef MEMARB_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             iREN,
  input  logic [31:0]      iaddr,
  output logic             iwait,
  output logic [31:0]      iload,
  input  logic             dREN,
  input  logic             dWEN,
  input  logic [31:0]      daddr,
  input  logic [31:0]      dstore,
  output logic             dwait,
  output logic [31:0]      dload,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic [1:0]       ramstate
`ifdef MEMARB_PERF_EN
  , output logic [CNT_W-1:0] perf_icnt
  , output logic [CNT_W-1:0] perf_dcnt
  , output logic [CNT_W-1:0] perf_stall
`endif
);

  typedef enum logic [1:0] {IDLE, ISERV, DSERV} state_e;

  state_e      state_q, state_d;
  logic        lastGrantD_q, lastGrantD_d;
  logic        ramREN_q, ramREN_d;
  logic        ramWEN_q, ramWEN_d;
  logic [31:0] ramaddr_q, ramaddr_d;
  logic [31:0] ramstore_q, ramstore_d;
  logic [31:0] iloadHold_q, iloadHold_d;
  logic [31:0] dloadHold_q, dloadHold_d;

  logic        dPending, ramDone, ramErr, grantD;
  logic        iComplete, dComplete, dReadComplete;
  logic [31:0] compData;

  // ACCESS (2) and ERROR (3) both end the access; ERROR substitutes the error word.
  assign dPending      = dREN | dWEN;
  assign ramDone       = ramstate[1];
  assign ramErr        = (ramstate == 2'd3);
  assign compData      = ramErr ? ERR_WORD : ramload;
  assign iComplete     = (state_q == ISERV) && iREN && ramDone;
  assign dComplete     = (state_q == DSERV) && dPending && ramDone;
  assign dReadComplete = dComplete && !ramWEN_q;

  assign iwait    = !iComplete;
  assign dwait    = !dComplete;
  assign iload    = iComplete ? compData : iloadHold_q;
  assign dload    = dReadComplete ? compData : dloadHold_q;
  assign ramREN   = ramREN_q;
  assign ramWEN   = ramWEN_q;
  assign ramaddr  = ramaddr_q;
  assign ramstore = ramstore_q;

  always_comb begin
    state_d      = state_q;
    lastGrantD_d = lastGrantD_q;
    ramREN_d     = ramREN_q;
    ramWEN_d     = ramWEN_q;
    ramaddr_d    = ramaddr_q;
    ramstore_d   = ramstore_q;
    iloadHold_d  = iComplete ? compData : iloadHold_q;
    dloadHold_d  = dReadComplete ? compData : dloadHold_q;
    grantD       = 1'b0;
    unique case (state_q)
      IDLE: begin
        // With both sides pending, alternate against the previous grant.
        grantD = (iREN && dPending) ? !lastGrantD_q : dPending;
        if (iREN || dPending) begin
          lastGrantD_d = grantD;
          if (grantD) begin
            state_d    = DSERV;
            ramaddr_d  = daddr;
            ramstore_d = dstore;
            ramWEN_d   = dWEN;
            ramREN_d   = !dWEN;
          end else begin
            state_d   = ISERV;
            ramaddr_d = iaddr;
            ramREN_d  = 1'b1;
            ramWEN_d  = 1'b0;
          end
        end
      end
      ISERV: begin
        if (!iREN || ramDone) begin
          state_d  = IDLE;
          ramREN_d = 1'b0;
          ramWEN_d = 1'b0;
        end
      end
      DSERV: begin
        if (!dPending || ramDone) begin
          state_d  = IDLE;
          ramREN_d = 1'b0;
          ramWEN_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        ramREN_d = 1'b0;
        ramWEN_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      lastGrantD_q <= 1'b0;
      ramREN_q     <= 1'b0;
      ramWEN_q     <= 1'b0;
      ramaddr_q    <= '0;
      ramstore_q   <= '0;
      iloadHold_q  <= '0;
      dloadHold_q  <= '0;
    end else begin
      state_q      <= state_d;
      lastGrantD_q <= lastGrantD_d;
      ramREN_q     <= ramREN_d;
      ramWEN_q     <= ramWEN_d;
      ramaddr_q    <= ramaddr_d;
      ramstore_q   <= ramstore_d;
      iloadHold_q  <= iloadHold_d;
      dloadHold_q  <= dloadHold_d;
    end
  end

`ifdef MEMARB_PERF_EN
  logic [CNT_W-1:0] icnt_q, dcnt_q, stall_q;
  logic             stallNow;

  // A stall cycle is one where some requester is pending but not being completed.
  assign stallNow   = (iREN && iwait) || (dPending && dwait);
  assign perf_icnt  = icnt_q;
  assign perf_dcnt  = dcnt_q;
  assign perf_stall = stall_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      icnt_q  <= '0;
      dcnt_q  <= '0;
      stall_q <= '0;
    end else begin
      if (iComplete) icnt_q  <= icnt_q + 1'b1;
      if (dComplete) dcnt_q  <= dcnt_q + 1'b1;
      if (stallNow)  stall_q <= stall_q + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter; perf counter checks are
// compiled in when MEMARB_PERF_EN is defined.
module tb_memory_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef MEMARB_PERF_EN
  logic [31:0] perf_icnt, perf_dcnt, perf_stall;
`endif

  int compared   = 0;
  int mismatched = 0;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  memory_arbiter dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
`ifdef MEMARB_PERF_EN
    , .perf_icnt(perf_icnt), .perf_dcnt(perf_dcnt), .perf_stall(perf_stall)
`endif
  );

  always #5 CLK = ~CLK;

  // Inputs change at the falling edge; outputs are checked 1 time unit later.
  task automatic test_reset();
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
    @(negedge CLK); @(negedge CLK); #1;
    compared++;
    if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100) begin
      mismatched++; $display("[TB] FAIL reset_ctrl got %b want 1100", {iwait, dwait, ramREN, ramWEN});
    end
    compared++;
    if ({iload, dload, ramaddr, ramstore} !== 128'd0) begin
      mismatched++; $display("[TB] FAIL reset_data got %h %h %h %h want zeros", iload, dload, ramaddr, ramstore);
    end
  endtask

  task automatic test_ifetch();
    @(negedge CLK); RST = 0; iREN = 1; iaddr = 32'h40; ramstate = FREE; #1;
    compared++;
    if ({iwait, ramREN} !== 2'b10) begin
      mismatched++; $display("[TB] FAIL ifetch_idle got %b want 10", {iwait, ramREN});
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK); ramstate = BUSY; #1;
      compared++;
      if ({iwait, ramREN, ramWEN, ramaddr} !== {3'b110, 32'h40}) begin
        mismatched++; $display("[TB] FAIL ifetch_busy%0d got %b %h want 110 00000040", k, {iwait, ramREN, ramWEN}, ramaddr);
      end
    end
    @(negedge CLK); ramstate = ACCESS; ramload = 32'h8C010004; #1;
    compared++;
    if ({iwait, dwait, iload} !== {2'b01, 32'h8C010004}) begin
      mismatched++; $display("[TB] FAIL ifetch_done got %b %h want 01 8c010004", {iwait, dwait}, iload);
    end
    @(negedge CLK); iREN = 0; ramstate = FREE; ramload = 32'h12345678; #1;
    compared++;
    if ({iwait, ramREN, iload} !== {2'b10, 32'h8C010004}) begin
      mismatched++; $display("[TB] FAIL ifetch_after got %b %h want 10 8c010004", {iwait, ramREN}, iload);
    end
  endtask

  task automatic test_dwrite();
    @(negedge CLK); dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramstate = FREE; #1;
    compared++;
    if (dwait !== 1'b1) begin
      mismatched++; $display("[TB] FAIL dwrite_idle got %b want 1", dwait);
    end
    @(negedge CLK); ramstate = BUSY; #1;
    compared++;
    if ({dwait, ramREN, ramWEN, ramaddr, ramstore} !== {3'b101, 32'h100, 32'hDEADBEEF}) begin
      mismatched++; $display("[TB] FAIL dwrite_busy got %b %h %h want 101 00000100 deadbeef", {dwait, ramREN, ramWEN}, ramaddr, ramstore);
    end
    @(negedge CLK); ramstate = ACCESS; ramload = 32'h55555555; #1;
    compared++;
    if ({iwait, dwait, dload} !== {2'b10, 32'h0}) begin
      mismatched++; $display("[TB] FAIL dwrite_done got %b %h want 10 00000000", {iwait, dwait}, dload);
    end
    @(negedge CLK); dWEN = 0; ramstate = FREE; #1;
    compared++;
    if ({dwait, ramWEN} !== 2'b10) begin
      mismatched++; $display("[TB] FAIL dwrite_after got %b want 10", {dwait, ramWEN});
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  expCtl;
    logic [31:0] expAddr;
    @(negedge CLK); RST = 1; iREN = 1; dREN = 1; iaddr = 32'h300; daddr = 32'h200; ramstate = ACCESS;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK); RST = 0; ramload = 32'hA0 + k; #1;
      expCtl  = (k % 2 == 0) ? 4'b1100 : ((k % 4 == 1) ? 4'b1010 : 4'b0110);
      expAddr = (k % 4 == 3) ? 32'h300 : 32'h200;
      compared++;
      if ({iwait, dwait, ramREN, ramWEN} !== expCtl) begin
        mismatched++; $display("[TB] FAIL alt_ctl%0d got %b want %b", k, {iwait, dwait, ramREN, ramWEN}, expCtl);
      end
      if (k % 2 == 1) begin
        compared++;
        if (ramaddr !== expAddr || ((k % 4 == 1) ? dload : iload) !== 32'hA0 + k) begin
          mismatched++; $display("[TB] FAIL alt_data%0d got addr %h iload %h dload %h", k, ramaddr, iload, dload);
        end
      end
    end
    @(negedge CLK); iREN = 0; dREN = 0; ramstate = FREE; #1;
`ifdef MEMARB_PERF_EN
    compared++;
    if ({perf_icnt, perf_dcnt, perf_stall} !== {32'd2, 32'd2, 32'd8}) begin
      mismatched++; $display("[TB] FAIL alt_perf got %0d %0d %0d want 2 2 8", perf_icnt, perf_dcnt, perf_stall);
    end
`endif
  endtask

  task automatic test_error();
    @(negedge CLK); dREN = 1; daddr = 32'h44; ramstate = FREE; #1;
    @(negedge CLK); ramstate = ERROR; ramload = 32'h11111111; #1;
    compared++;
    if ({dwait, ramREN, dload} !== {2'b01, 32'hBAD1BAD1}) begin
      mismatched++; $display("[TB] FAIL err_read got %b %h want 01 bad1bad1", {dwait, ramREN}, dload);
    end
    @(negedge CLK); dWEN = 1; daddr = 32'h48; dstore = 32'h77; ramstate = FREE; #1;
    compared++;
    if ({dwait, dload} !== {1'b1, 32'hBAD1BAD1}) begin
      mismatched++; $display("[TB] FAIL err_hold got %b %h want 1 bad1bad1", dwait, dload);
    end
    @(negedge CLK); ramstate = ERROR; ramload = 32'h22222222; #1;
    compared++;
    if ({iwait, dwait, ramREN, ramWEN, ramstore, dload} !== {4'b1001, 32'h77, 32'hBAD1BAD1}) begin
      mismatched++; $display("[TB] FAIL err_write got %b %h %h want 1001 00000077 bad1bad1", {iwait, dwait, ramREN, ramWEN}, ramstore, dload);
    end
    @(negedge CLK); dREN = 0; dWEN = 0; ramstate = FREE; #1;
    compared++;
    if ({dwait, ramWEN} !== 2'b10) begin
      mismatched++; $display("[TB] FAIL err_after got %b want 10", {dwait, ramWEN});
    end
  endtask

  task automatic test_abort();
    @(negedge CLK); iREN = 1; iaddr = 32'h80; ramstate = FREE; #1;
    @(negedge CLK); iaddr = 32'h99; ramstate = BUSY; #1;
    compared++;
    if ({iwait, ramREN, ramaddr} !== {2'b11, 32'h80}) begin
      mismatched++; $display("[TB] FAIL abort_busy got %b %h want 11 00000080", {iwait, ramREN}, ramaddr);
    end
    @(negedge CLK); iREN = 0; #1;
    compared++;
    if ({iwait, ramREN} !== 2'b11) begin
      mismatched++; $display("[TB] FAIL abort_drop got %b want 11", {iwait, ramREN});
    end
    @(negedge CLK); ramstate = ACCESS; #1;
    compared++;
    if ({iwait, ramREN, ramWEN} !== 3'b100) begin
      mismatched++; $display("[TB] FAIL abort_after got %b want 100", {iwait, ramREN, ramWEN});
    end
    @(negedge CLK); ramstate = FREE;
  endtask

  task automatic test_reset_mid_write();
    @(negedge CLK); dWEN = 1; daddr = 32'h10; dstore = 32'h55; ramstate = FREE; #1;
    @(negedge CLK); ramstate = BUSY; #1;
    compared++;
    if (ramWEN !== 1'b1) begin
      mismatched++; $display("[TB] FAIL rstw_busy got %b want 1", ramWEN);
    end
    @(negedge CLK); RST = 1; #1;
    @(negedge CLK); RST = 0; dWEN = 0; ramstate = FREE; #1;
    compared++;
    if ({ramREN, ramWEN, dwait, ramaddr, ramstore, iload, dload} !== {3'b001, 128'd0}) begin
      mismatched++; $display("[TB] FAIL rstw_clear got %b %h %h %h %h", {ramREN, ramWEN, dwait}, ramaddr, ramstore, iload, dload);
    end
`ifdef MEMARB_PERF_EN
    compared++;
    if ({perf_icnt, perf_dcnt, perf_stall} !== 96'd0) begin
      mismatched++; $display("[TB] FAIL rstw_perf got %0d %0d %0d want 0 0 0", perf_icnt, perf_dcnt, perf_stall);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_ifetch();
    test_dwrite();
    test_back_to_back();
    test_error();
    test_abort();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
